bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 98 +++++++++
 tb/tb_bit_serializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with optional idle gap between words.
// One word in flight; a new word may load on the last bit when no gap is configured.
module bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter int   GAP        = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_bit,
  output logic             o_bit_valid,
  output logic             o_done
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, GAPW} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             bit_q, bit_d;
  logic             vld_q, vld_d;
  logic             last, accept, load;

  assign last    = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
  assign o_ready = (state_q == IDLE) || (last && (GAP == 0));
  assign accept  = i_valid && o_ready;

  assign o_bit       = bit_q;
  assign o_bit_valid = vld_q;
  assign o_done      = last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sreg_d  = sreg_q;
    bit_d   = IDLE_LEVEL;
    vld_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: load = accept;
      SHIFT: begin
        if (last) begin
          if (GAP > 0) begin
            state_d = GAPW;
            gap_d   = 4'd0;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          // The bit presented next cycle sits one position inside the register.
          cnt_d  = cnt_q + CW'(1);
          sreg_d = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
          bit_d  = (MSB_FIRST != 0) ? sreg_q[WIDTH-2] : sreg_q[1];
          vld_d  = 1'b1;
        end
      end
      GAPW: begin
        if (gap_q == 4'(GAP - 1)) state_d = IDLE;
        else                      gap_d   = gap_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sreg_d  = i_data;
      bit_d   = (MSB_FIRST != 0) ? i_data[WIDTH-1] : i_data[0];
      vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      sreg_q  <= '0;
      bit_q   <= IDLE_LEVEL;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// Three serializer configurations checked against a timeline model every cycle,
// plus directed sequences with literal expected bit patterns.
module tb_bit_serializer;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data  [3];
  logic       valid [3];
  logic       rdy [3], obit [3], ovld [3], odone [3];

  int tests = 0, fails = 0, cyc = 0;
  bit chk_on = 1'b0;

  int   MSBF [3] = '{1, 0, 1};
  int   GAPV [3] = '{0, 0, 2};
  logic IL   [3] = '{1'b0, 1'b1, 1'b0};

  // model state: word accepted at edge a is shown in periods a..a+7
  bit         hw  [3];
  int         a   [3];
  int         idf [3];
  logic [7:0] wd  [3];
  logic       mrdy [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0), .IDLE_LEVEL(1'b0)) u0 (
    .clk(clk), .rst(rst), .i_data(data[0]), .i_valid(valid[0]), .o_ready(rdy[0]),
    .o_bit(obit[0]), .o_bit_valid(ovld[0]), .o_done(odone[0]));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(0), .IDLE_LEVEL(1'b1)) u1 (
    .clk(clk), .rst(rst), .i_data(data[1]), .i_valid(valid[1]), .o_ready(rdy[1]),
    .o_bit(obit[1]), .o_bit_valid(ovld[1]), .o_done(odone[1]));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(2), .IDLE_LEVEL(1'b0)) u2 (
    .clk(clk), .rst(rst), .i_data(data[2]), .i_valid(valid[2]), .o_ready(rdy[2]),
    .o_bit(obit[2]), .o_bit_valid(ovld[2]), .o_done(odone[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int  p, k;
    bit  in_w;
    logic erdy, ebit, edone;
    p = cyc;
    for (int i = 0; i < 3; i++) begin
      in_w  = hw[i] && p >= a[i] && p <= a[i] + 7;
      k     = p - a[i];
      erdy  = in_w ? (GAPV[i] == 0 && p == a[i] + 7) : (p >= idf[i]);
      ebit  = in_w ? ((MSBF[i] != 0) ? wd[i][7-k] : wd[i][k]) : IL[i];
      edone = in_w && p == a[i] + 7;
      if (chk_on) begin
        chk($sformatf("m%0d_ready", i), rdy[i], erdy);
        chk($sformatf("m%0d_valid", i), ovld[i], in_w);
        chk($sformatf("m%0d_bit", i), obit[i], ebit);
        chk($sformatf("m%0d_done", i), odone[i], edone);
      end
      mrdy[i] = erdy;
      if (rst) begin
        hw[i] = 1'b0; idf[i] = p + 1;
      end else if (valid[i] && erdy) begin
        hw[i] = 1'b1; a[i] = p + 1; wd[i] = data[i]; idf[i] = p + 1 + 8 + GAPV[i];
      end
    end
  end

  // returns #1 after the accepting edge, i.e. in the period showing bit 0
  task automatic send(input int i, input logic [7:0] w);
    int n = 0;
    data[i] = w; valid[i] = 1'b1;
    do begin
      @(negedge clk); #1; n++;
    end while (!mrdy[i] && n < 200);
    if (!mrdy[i]) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_bits(input int i, input logic [15:0] pat, input logic [15:0] rmask, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("lit%0d_bit%0d", i, k), obit[i], pat[n-1-k]);
      chk($sformatf("lit%0d_vld%0d", i, k), ovld[i], 1'b1);
      chk($sformatf("lit%0d_rdy%0d", i, k), rdy[i], rmask[n-1-k]);
      chk($sformatf("lit%0d_done%0d", i, k), odone[i], (k % 8) == 7);
    end
    @(negedge clk);
    chk($sformatf("lit%0d_tail_vld", i), ovld[i], 1'b0);
    chk($sformatf("lit%0d_tail_bit", i), obit[i], IL[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0; data[i] = 8'h00; hw[i] = 1'b0; a[i] = 0; idf[i] = 0; wd[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_bit", obit[i], IL[i]);
      chk("rst_vld", ovld[i], 1'b0);
      chk("rst_done", odone[i], 1'b0);
      chk("rst_rdy", rdy[i], 1'b1);
    end
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // MSB first 0xB4
    send(0, 8'hB4); valid[0] = 1'b0;
    chk_bits(0, 16'h00B4, 16'h0001, 8);
    idle(3);

    // LSB first 0xB4, then i_data changes while busy
    send(1, 8'hB4);
    fork
      chk_bits(1, 16'h2D00, 16'h0101, 16);
      begin
        valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 send(1, 8'h00); valid[1] = 1'b0;
      end
    join
    idle(3);

    // back-to-back stream with no gap
    send(0, 8'hFF);
    fork
      chk_bits(0, 16'hFF0D, 16'h0101, 16);
      begin send(0, 8'h0D); valid[0] = 1'b0; end
    join
    idle(3);

    // gap of two idle cycles after each word
    send(2, 8'hA5);
    pat = 8'hA5;
    fork
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        chk($sformatf("gap_vld%0d", k), ovld[2], (k < 8) || (k == 11));
        chk($sformatf("gap_rdy%0d", k), rdy[2], k == 10);
        chk($sformatf("gap_done%0d", k), odone[2], k == 7);
        if (k < 8) chk($sformatf("gap_bit%0d", k), obit[2], pat[7-k]);
        if (k == 11) chk("gap_bit2nd", obit[2], 1'b1);
      end
      begin send(2, 8'hC3); valid[2] = 1'b0; end
    join
    idle(12);

    // reset during the 4th bit
    send(0, 8'h96); valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_vld", ovld[0], 1'b0);
    chk("midrst_rdy", rdy[0], 1'b1);
    idle(6);
    send(0, 8'h5A); valid[0] = 1'b0;
    chk_bits(0, 16'h005A, 16'h0001, 8);
    idle(2);

    // reset wins over a simultaneous accept
    data[0] = 8'hFF; valid[0] = 1'b1; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; valid[0] = 1'b0;
    @(negedge clk);
    chk("rstacc_vld", ovld[0], 1'b0);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
